// File: rtl/upload_mcast_fsm_datapath.sv
// upload_mcast_fsm_datapath: latches one request message and sends it to the request FIFO as head, body and tail flits; in multicast mode it sends one copy per bitmap target, with dest = node index (in: msg fields, fifo rdy; out: flit/ctrl/valid, state, rdy, done)
module upload_mcast_fsm_datapath #(
  parameter int FLIT_W = 16,
  parameter int NODE_NUM = 4,
  parameter int MAX_DATA = 4,
  parameter int DEST_LSB = 12,
  parameter int DEST_W = 2,
  localparam int CW = $clog2(MAX_DATA + 3)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       v_flits_in,
  input  logic                       en_inv_ids,
  input  logic [NODE_NUM-1:0]        inv_ids_in,
  input  logic [CW-1:0]              flits_max_in,
  input  logic [FLIT_W-1:0]          head_flit,
  input  logic [FLIT_W-1:0]          addrhi,
  input  logic [FLIT_W-1:0]          addrlo,
  input  logic [MAX_DATA*FLIT_W-1:0] data_in,
  input  logic                       out_req_fifo_rdy_in,
  output logic [FLIT_W-1:0]          flit_out,
  output logic [1:0]                 ctrl_out,
  output logic                       v_flit_to_req_fifo,
  output logic [1:0]                 fsm_state,
  output logic                       upload_rdy,
  output logic                       upload_done
);
  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, SEND = 2'b10} state_t;
  state_t state;
  logic [FLIT_W-1:0] head_r, hi_r, lo_r, hdr_r, hdr_nx, data_sel;
  logic [MAX_DATA*FLIT_W-1:0] data_r;
  logic [NODE_NUM-1:0] mask_r;
  logic [DEST_W-1:0] sel_r, low_idx;
  logic [CW-1:0] len_r, cnt, len_in, di;
  logic mc_r, send, tail;
  assign len_in = flits_max_in < CW'(2) ? CW'(2) :
                  flits_max_in > CW'(MAX_DATA + 2) ? CW'(MAX_DATA + 2) : flits_max_in;
  assign send = state == SEND;
  assign tail = cnt == len_r;
  assign di = cnt - CW'(3);
  always_comb begin
    low_idx = '0;
    for (int k = NODE_NUM - 1; k >= 0; k--) low_idx = mask_r[k] ? DEST_W'(k) : low_idx;
  end
  always_comb begin
    hdr_nx = head_r;
    if (mc_r) hdr_nx[DEST_LSB +: DEST_W] = low_idx;
  end
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < MAX_DATA; k++) data_sel = di == CW'(k) ? data_r[k*FLIT_W +: FLIT_W] : data_sel;
  end
  assign flit_out = !send ? '0 : cnt == CW'(0) ? hdr_r : cnt == CW'(1) ? hi_r :
                    cnt == CW'(2) ? lo_r : data_sel;
  assign ctrl_out = !send ? 2'b00 : cnt == CW'(0) ? 2'b01 : tail ? 2'b11 : 2'b10;
  assign v_flit_to_req_fifo = send & out_req_fifo_rdy_in;
  assign fsm_state = state;
  assign upload_rdy = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      head_r <= '0;
      hi_r <= '0;
      lo_r <= '0;
      hdr_r <= '0;
      data_r <= '0;
      mask_r <= '0;
      sel_r <= '0;
      len_r <= '0;
      cnt <= '0;
      mc_r <= 1'b0;
      upload_done <= 1'b0;
    end else begin
      upload_done <= 1'b0;
      case (state)
        IDLE: if (v_flits_in) begin
          head_r <= head_flit;
          hi_r <= addrhi;
          lo_r <= addrlo;
          data_r <= data_in;
          len_r <= len_in;
          mc_r <= en_inv_ids;
          mask_r <= en_inv_ids ? inv_ids_in : NODE_NUM'(1);
          state <= SCAN;
        end
        SCAN: if (mask_r == '0) begin
          upload_done <= 1'b1;
          state <= IDLE;
        end else begin
          sel_r <= low_idx;
          hdr_r <= hdr_nx;
          cnt <= '0;
          state <= SEND;
        end
        SEND: if (out_req_fifo_rdy_in) begin
          cnt <= tail ? '0 : cnt + CW'(1);
          if (tail) begin
            mask_r <= mask_r & ~(NODE_NUM'(1) << sel_r);
            upload_done <= !mc_r;
            state <= mc_r ? SCAN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upload_mcast_fsm_datapath.sv
// tb_upload_mcast_fsm_datapath: table, hand-written and random messages checked against a flit-list reference model
module tb_upload_mcast_fsm_datapath;
  localparam int FW = 16, NN = 4, MD = 4, DL = 12, DW = 2, CW = $clog2(MD + 3);
  logic clk = 0, rst = 1, v = 0, en = 0, rdy = 1;
  logic [NN-1:0] ids = '0;
  logic [CW-1:0] fmax = '0;
  logic [FW-1:0] head = '0, hi = '0, lo = '0;
  logic [MD*FW-1:0] data = '0;
  logic [FW-1:0] flit;
  logic [1:0] ctrl, st;
  logic vo, urdy, done;
  int checks = 0, errors = 0;
  logic [FW+1:0] exp_q[$];
  typedef struct {
    logic e;
    logic [NN-1:0] m;
    logic [CW-1:0] fm;
    logic [FW-1:0] h;
    int nfl;
    int dcyc;
  } vec_t;
  vec_t vecs[8];
  always #5 clk = ~clk;
  upload_mcast_fsm_datapath #(.FLIT_W(FW), .NODE_NUM(NN), .MAX_DATA(MD), .DEST_LSB(DL), .DEST_W(DW)) dut (
    .clk(clk), .rst(rst), .v_flits_in(v), .en_inv_ids(en), .inv_ids_in(ids), .flits_max_in(fmax),
    .head_flit(head), .addrhi(hi), .addrlo(lo), .data_in(data), .out_req_fifo_rdy_in(rdy),
    .flit_out(flit), .ctrl_out(ctrl), .v_flit_to_req_fifo(vo), .fsm_state(st),
    .upload_rdy(urdy), .upload_done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void build(input logic e, input logic [NN-1:0] m, input int fm,
                                input logic [FW-1:0] h, a, b, input logic [MD*FW-1:0] d);
    int len;
    logic [FW-1:0] f;
    logic [1:0] k;
    len = fm < 2 ? 2 : fm > MD + 2 ? MD + 2 : fm;
    exp_q.delete();
    for (int n = 0; n < NN; n++)
      if (e ? m[n] : n == 0)
        for (int c = 0; c <= len; c++) begin
          if (c == 0) begin
            f = h;
            if (e) f[DL +: DW] = DW'(n);
          end else if (c == 1) f = a;
          else if (c == 2) f = b;
          else f = d[(c-3)*FW +: FW];
          k = c == 0 ? 2'b01 : c == len ? 2'b11 : 2'b10;
          exp_q.push_back({k, f});
        end
  endfunction
  task automatic run_msg(input logic e, input logic [NN-1:0] m, input logic [CW-1:0] fm,
                         input logic [FW-1:0] h, input int mode, output int nfl, output int dcyc);
    logic [FW+1:0] x;
    int exp_n;
    build(e, m, int'(fm), h, hi, lo, data);
    exp_n = exp_q.size();
    nfl = 0;
    dcyc = -1;
    en = e; ids = m; fmax = fm; head = h; v = 1; rdy = 1;
    @(negedge clk);
    v = 0;
    for (int cyc = 1; cyc < 400 && dcyc < 0; cyc++) begin
      rdy = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? !(cyc >= 4 && cyc <= 6) : 1'b1;
      #1;
      if (mode == 2 && cyc >= 4 && cyc <= 6) begin
        chk("stall_valid", vo, 0);
        chk("stall_flit", flit, lo);
      end
      if (vo) begin
        nfl++;
        x = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        chk("flit", {ctrl, flit}, x);
      end
      if (done) dcyc = cyc;
      else @(negedge clk);
    end
    chk("done_seen", dcyc >= 0, 1);
    chk("flit_count", nfl, exp_n);
    chk("idle_after", st, 0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask
  initial begin
    int n, d;
    vecs[0] = '{1'b0, 4'b0000, 3'd4, 16'h1234, 5, 7};
    vecs[1] = '{1'b1, 4'b1011, 3'd2, 16'h0000, 9, 14};
    vecs[2] = '{1'b1, 4'b0000, 3'd3, 16'hABCD, 0, 2};
    vecs[3] = '{1'b0, 4'b0000, 3'd7, 16'h5555, 7, 9};
    vecs[4] = '{1'b0, 4'b0000, 3'd0, 16'h0F0F, 3, 5};
    vecs[5] = '{1'b1, 4'b1000, 3'd3, 16'hFFFF, 4, 7};
    vecs[6] = '{1'b1, 4'b1111, 3'd6, 16'h0123, 28, 34};
    vecs[7] = '{1'b0, 4'b1111, 3'd2, 16'h4321, 3, 5};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flit", flit, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_valid", vo, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", urdy, 1);
    chk("rst_state", st, 0);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      hi = 16'hA100 + 16'(i);
      lo = 16'hB200 + 16'(i);
      data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      run_msg(vecs[i].e, vecs[i].m, vecs[i].fm, vecs[i].h, 0, n, d);
      chk($sformatf("vec%0d_flits", i), n, vecs[i].nfl);
      chk($sformatf("vec%0d_done_cycle", i), d, vecs[i].dcyc);
    end
    hi = 16'h1111; lo = 16'h2222;
    run_msg(1'b0, 4'b0000, 3'd4, 16'h1234, 2, n, d);
    chk("stall_flits", n, 5);
    chk("stall_done_cycle", d, 10);
    hi = 16'h3333; lo = 16'h4444; data = {$urandom, $urandom};
    en = 0; fmax = 3'd6; head = 16'h7777; rdy = 1; v = 1;
    @(negedge clk);
    v = 0;
    @(negedge clk);
    #1;
    chk("busy_state", st, 2);
    chk("busy_rdy", urdy, 0);
    chk("busy_head", {ctrl, flit}, {2'b01, 16'h7777});
    v = 1; head = 16'h1111;
    @(negedge clk);
    v = 0;
    #1;
    chk("busy_ignore", {ctrl, flit}, {2'b10, 16'h3333});
    rst = 1;
    @(negedge clk);
    #1;
    chk("midrst_flit", flit, 0);
    chk("midrst_ctrl", ctrl, 0);
    chk("midrst_valid", vo, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rdy", urdy, 1);
    chk("midrst_state", st, 0);
    rst = 0;
    @(negedge clk);
    run_msg(1'b1, 4'b0110, 3'd5, 16'h8888, 0, n, d);
    chk("after_rst_flits", n, 12);
    for (int i = 0; i < 25; i++) begin
      hi = FW'($urandom); lo = FW'($urandom); data = {$urandom, $urandom};
      run_msg(1'($urandom), NN'($urandom), CW'($urandom_range(0, 7)), FW'($urandom), 1, n, d);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
